// File: rtl/hazard_control_unit_if.sv
// Pipeline-control bundle between the core datapath (master) and the hazard
// control unit (slave): hazard sources in, stage enables/flushes and MDU control out.
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_if_id_i;
  logic [4:0]       rs2_if_id_i;
  logic             rs1_used_i;
  logic             rs2_used_i;
  logic [4:0]       rd_id_ex_i;
  logic             mem_read_id_ex_en;
  logic             mdu_valid_id_ex_en;
  logic             mdu_done_i;
  logic             branch_taken_ex_i;
  logic             flush_i;
  logic             perf_clear_i;

  logic             pc_write_en_o;
  logic             if_id_write_en_o;
  logic             id_ex_write_en_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             ex_mem_bubble_o;
  logic             mdu_start_o;
  logic             mdu_abort_o;
  logic             mdu_result_sel_o;
  logic             mdu_timeout_o;
  logic [CNT_W-1:0] stall_cycles_o;

  modport master (
    output rs1_if_id_i, rs2_if_id_i, rs1_used_i, rs2_used_i, rd_id_ex_i,
           mem_read_id_ex_en, mdu_valid_id_ex_en, mdu_done_i,
           branch_taken_ex_i, flush_i, perf_clear_i,
    input  pc_write_en_o, if_id_write_en_o, id_ex_write_en_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_bubble_o,
           mdu_start_o, mdu_abort_o, mdu_result_sel_o,
           mdu_timeout_o, stall_cycles_o
  );

  modport slave (
    input  rs1_if_id_i, rs2_if_id_i, rs1_used_i, rs2_used_i, rd_id_ex_i,
           mem_read_id_ex_en, mdu_valid_id_ex_en, mdu_done_i,
           branch_taken_ex_i, flush_i, perf_clear_i,
    output pc_write_en_o, if_id_write_en_o, id_ex_write_en_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_bubble_o,
           mdu_start_o, mdu_abort_o, mdu_result_sel_o,
           mdu_timeout_o, stall_cycles_o
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use bubbles, multi-cycle MDU freeze with watchdog,
// branch/trap flushes and a saturating stall-cycle counter.
module hazard_control_unit #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic                   clk_i,
  input logic                   rst_i,
  hazard_control_unit_if.slave  hz_if
);

  localparam int WCNT_W = $clog2(MDU_TIMEOUT);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_stall_cnt;

  state_t              w_next_state;
  logic [WCNT_W-1:0]   w_wait_cnt_nxt;
  logic                w_timeout_set;
  logic                w_load_use;
  logic                w_redirect;
  logic                w_wait_expired;

  logic                w_pc_we;
  logic                w_if_id_we;
  logic                w_id_ex_we;
  logic                w_if_id_flush;
  logic                w_id_ex_flush;
  logic                w_ex_mem_bubble;
  logic                w_mdu_start;
  logic                w_mdu_abort;
  logic                w_mdu_sel;

  // A load writing x0 never creates a dependency.
  assign w_load_use = hz_if.mem_read_id_ex_en && (hz_if.rd_id_ex_i != 5'd0) &&
                      ((hz_if.rs1_used_i && (hz_if.rd_id_ex_i == hz_if.rs1_if_id_i)) ||
                       (hz_if.rs2_used_i && (hz_if.rd_id_ex_i == hz_if.rs2_if_id_i)));

  assign w_redirect     = hz_if.flush_i || hz_if.branch_taken_ex_i;
  assign w_wait_expired = (r_wait_cnt == WCNT_W'(MDU_TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    w_pc_we         = 1'b1;
    w_if_id_we      = 1'b1;
    w_id_ex_we      = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_mdu_start     = 1'b0;
    w_mdu_abort     = 1'b0;
    w_mdu_sel       = 1'b0;
    w_next_state    = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_timeout_set   = 1'b0;

    if (rst_i) begin
      // Outputs react to reset immediately, not at the next edge.
      w_pc_we       = 1'b0;
      w_if_id_we    = 1'b0;
      w_id_ex_we    = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_next_state  = ST_RUN;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_redirect) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (hz_if.mdu_valid_id_ex_en) begin
            w_mdu_start     = 1'b1;
            w_pc_we         = 1'b0;
            w_if_id_we      = 1'b0;
            w_id_ex_we      = 1'b0;
            w_ex_mem_bubble = 1'b1;
            w_wait_cnt_nxt  = '0;
            w_next_state    = ST_MDU_WAIT;
          end else if (w_load_use) begin
            w_pc_we       = 1'b0;
            w_if_id_we    = 1'b0;
            w_id_ex_flush = 1'b1;
          end
        end

        ST_MDU_WAIT: begin
          if (hz_if.flush_i) begin
            w_mdu_abort     = 1'b1;
            w_if_id_flush   = 1'b1;
            w_id_ex_flush   = 1'b1;
            w_ex_mem_bubble = 1'b1;
            w_next_state    = ST_RUN;
          end else if (hz_if.mdu_done_i) begin
            w_mdu_sel    = 1'b1;
            w_next_state = ST_RUN;
          end else if (w_wait_expired) begin
            w_mdu_abort     = 1'b1;
            w_timeout_set   = 1'b1;
            w_ex_mem_bubble = 1'b1;
            w_id_ex_flush   = 1'b1;
            w_next_state    = ST_RUN;
          end else begin
            w_pc_we         = 1'b0;
            w_if_id_we      = 1'b0;
            w_id_ex_we      = 1'b0;
            w_ex_mem_bubble = 1'b1;
            w_wait_cnt_nxt  = r_wait_cnt + WCNT_W'(1);
          end
        end

        default: w_next_state = ST_RUN;
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Clear beats increment; the count parks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (hz_if.perf_clear_i) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_we && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign hz_if.pc_write_en_o    = w_pc_we;
  assign hz_if.if_id_write_en_o = w_if_id_we;
  assign hz_if.id_ex_write_en_o = w_id_ex_we;
  assign hz_if.if_id_flush_o    = w_if_id_flush;
  assign hz_if.id_ex_flush_o    = w_id_ex_flush;
  assign hz_if.ex_mem_bubble_o  = w_ex_mem_bubble;
  assign hz_if.mdu_start_o      = w_mdu_start;
  assign hz_if.mdu_abort_o      = w_mdu_abort;
  assign hz_if.mdu_result_sel_o = w_mdu_sel;
  assign hz_if.mdu_timeout_o    = r_timeout;
  assign hz_if.stall_cycles_o   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed hazard scenarios, then
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_hazard_control_unit;

  localparam int MDU_TIMEOUT = 8;
  localparam int CNT_W       = 8;
  localparam int STALL_MAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_used;
    logic       rs2_used;
    logic       mem_read;
    logic       mdu_valid;
    logic       mdu_done;
    logic       branch;
    logic       flush;
    logic       perf_clear;
  } stim_t;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic bubble;
    logic start;
    logic abort;
    logic sel;
  } ctl_t;

  localparam logic [8:0] RST_CTL   = 9'b000_11_0_000;
  localparam logic [8:0] RUN_CTL   = 9'b111_00_0_000;
  localparam logic [8:0] LU_CTL    = 9'b001_01_0_000;
  localparam logic [8:0] START_CTL = 9'b000_00_1_100;
  localparam logic [8:0] HOLD_CTL  = 9'b000_00_1_000;
  localparam logic [8:0] DONE_CTL  = 9'b111_00_0_001;
  localparam logic [8:0] TO_CTL    = 9'b111_01_1_010;
  localparam logic [8:0] FLA_CTL   = 9'b111_11_1_010;
  localparam logic [8:0] REDIR_CTL = 9'b111_11_0_000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_control_unit #(
    .MDU_TIMEOUT(MDU_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz_if (hz)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: is an MDU op outstanding, how long it has waited, counters.
  bit          m_busy   = 1'b0;
  int          m_waited = 0;
  int unsigned m_stall  = 0;
  bit          m_to     = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic ctl_t ctl_now();
    ctl_t c;
    c.pc_we       = hz.pc_write_en_o;
    c.if_id_we    = hz.if_id_write_en_o;
    c.id_ex_we    = hz.id_ex_write_en_o;
    c.if_id_flush = hz.if_id_flush_o;
    c.id_ex_flush = hz.id_ex_flush_o;
    c.bubble      = hz.ex_mem_bubble_o;
    c.start       = hz.mdu_start_o;
    c.abort       = hz.mdu_abort_o;
    c.sel         = hz.mdu_result_sel_o;
    return c;
  endfunction

  task automatic drive(input stim_t s);
    hz.rs1_if_id_i        = s.rs1;
    hz.rs2_if_id_i        = s.rs2;
    hz.rd_id_ex_i         = s.rd;
    hz.rs1_used_i         = s.rs1_used;
    hz.rs2_used_i         = s.rs2_used;
    hz.mem_read_id_ex_en  = s.mem_read;
    hz.mdu_valid_id_ex_en = s.mdu_valid;
    hz.mdu_done_i         = s.mdu_done;
    hz.branch_taken_ex_i  = s.branch;
    hz.flush_i            = s.flush;
    hz.perf_clear_i       = s.perf_clear;
  endtask

  // Expected controls for this cycle, then advance the model across the edge.
  task automatic model_cycle(input stim_t s, output ctl_t e);
    bit lu;
    lu = s.mem_read && (s.rd != 0) &&
         ((s.rs1_used && s.rd == s.rs1) || (s.rs2_used && s.rd == s.rs2));
    e = ctl_t'(RUN_CTL);
    if (!m_busy) begin
      if (s.flush || s.branch) begin
        e.if_id_flush = 1'b1;
        e.id_ex_flush = 1'b1;
      end else if (s.mdu_valid) begin
        e = ctl_t'(START_CTL);
        m_busy   = 1'b1;
        m_waited = 0;
      end else if (lu) begin
        e.pc_we       = 1'b0;
        e.if_id_we    = 1'b0;
        e.id_ex_flush = 1'b1;
      end
    end else begin
      if (s.flush) begin
        e = ctl_t'(FLA_CTL);
        m_busy = 1'b0;
      end else if (s.mdu_done) begin
        e.sel  = 1'b1;
        m_busy = 1'b0;
      end else if (m_waited == MDU_TIMEOUT - 1) begin
        e = ctl_t'(TO_CTL);
        m_to   = 1'b1;
        m_busy = 1'b0;
      end else begin
        e = ctl_t'(HOLD_CTL);
        m_waited++;
      end
    end
    if (s.perf_clear)                          m_stall = 0;
    else if (!e.pc_we && m_stall < STALL_MAX)  m_stall++;
  endtask

  // One clock of stimulus; leaves inputs applied until the next negedge.
  task automatic step(input stim_t s);
    ctl_t e;
    @(negedge clk);
    drive(s);
    rst = 1'b0;
    #1;
    check("stall_cycles", 32'(hz.stall_cycles_o), m_stall);
    check("mdu_timeout", 32'(hz.mdu_timeout_o), 32'(m_to));
    model_cycle(s, e);
    check("ctl", 32'(ctl_now()), 32'(e));
  endtask

  // Asserts reset between edges; the following step() releases it.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    check("rst_ctl", 32'(ctl_now()), 32'(RST_CTL));
    check("rst_stall", 32'(hz.stall_cycles_o), 0);
    check("rst_timeout", 32'(hz.mdu_timeout_o), 0);
    m_busy = 1'b0; m_waited = 0; m_stall = 0; m_to = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_hold_ctl", 32'(ctl_now()), 32'(RST_CTL));
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs1        = 5'($urandom_range(0, 3));
    s.rs2        = 5'($urandom_range(0, 3));
    s.rd         = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    s.rs1_used   = 1'($urandom_range(0, 1));
    s.rs2_used   = 1'($urandom_range(0, 1));
    s.mem_read   = ($urandom_range(0, 2) == 0);
    s.mdu_valid  = ($urandom_range(0, 9) == 0);
    s.mdu_done   = ($urandom_range(0, 5) == 0);
    s.branch     = ($urandom_range(0, 9) == 0);
    s.flush      = ($urandom_range(0, 19) == 0);
    s.perf_clear = ($urandom_range(0, 299) == 0);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    stim_t idle, s;
    idle = '0;
    drive(idle);
    #2;
    do_reset(2);

    // Load-use on rs1, then the non-hazard variants.
    s = idle; s.rd = 5'd5; s.mem_read = 1'b1; s.rs1 = 5'd5; s.rs1_used = 1'b1;
    step(s);
    check("lu_ctl", 32'(ctl_now()), 32'(LU_CTL));
    s.rd = 5'd0; s.rs1 = 5'd0;
    step(s);
    check("lu_rd0_ctl", 32'(ctl_now()), 32'(RUN_CTL));
    s.rd = 5'd5; s.rs1 = 5'd5; s.rs1_used = 1'b0;
    step(s);
    check("lu_unused_ctl", 32'(ctl_now()), 32'(RUN_CTL));

    // MDU completing four cycles after start.
    s = idle; s.perf_clear = 1'b1; step(s);
    s = idle; s.mdu_valid = 1'b1; step(s);
    check("mdu_start_ctl", 32'(ctl_now()), 32'(START_CTL));
    repeat (3) step(idle);
    check("mdu_hold_ctl", 32'(ctl_now()), 32'(HOLD_CTL));
    s = idle; s.mdu_done = 1'b1; step(s);
    check("mdu_done_ctl", 32'(ctl_now()), 32'(DONE_CTL));
    @(posedge clk); #1;
    check("mdu_stall_total", 32'(hz.stall_cycles_o), 4);

    // Branch with simultaneous load-use, then flush during MDU_WAIT.
    s = idle; s.branch = 1'b1; s.rd = 5'd7; s.mem_read = 1'b1; s.rs2 = 5'd7; s.rs2_used = 1'b1;
    step(s);
    check("branch_lu_ctl", 32'(ctl_now()), 32'(REDIR_CTL));
    s = idle; s.mdu_valid = 1'b1; step(s);
    step(idle);
    s = idle; s.flush = 1'b1; step(s);
    check("mdu_flush_ctl", 32'(ctl_now()), 32'(FLA_CTL));

    // Watchdog: no done, abort on the last allowed wait cycle.
    s = idle; s.mdu_valid = 1'b1; step(s);
    repeat (MDU_TIMEOUT - 1) step(idle);
    step(idle);
    check("mdu_timeout_ctl", 32'(ctl_now()), 32'(TO_CTL));
    @(posedge clk); #1;
    check("mdu_timeout_set", 32'(hz.mdu_timeout_o), 1);
    repeat (3) step(idle);

    // Asynchronous reset in the middle of an MDU wait.
    s = idle; s.mdu_valid = 1'b1; step(s);
    step(idle);
    #2;
    do_reset(1);
    step(idle);

    // Saturation and clear priority.
    s = idle; s.rd = 5'd3; s.mem_read = 1'b1; s.rs1 = 5'd3; s.rs1_used = 1'b1;
    repeat (STALL_MAX + 5) step(s);
    @(posedge clk); #1;
    check("stall_saturated", 32'(hz.stall_cycles_o), STALL_MAX);
    s.perf_clear = 1'b1; step(s);
    @(posedge clk); #1;
    check("stall_clear_wins", 32'(hz.stall_cycles_o), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(rand_stim());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
